// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter. Accepts a byte strobe while idle and shifts
// one start bit, eight data bits (LSB first), an optional parity bit and one or
// two stop bits onto o_Tx_Serial. o_Tx_Active doubles as the producer's busy flag.
module uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       tx_byte;

  // Last cycle of the current bit period.
  logic bit_end;
  assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Frame sequencer: owns every output so all of them come straight from flops.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      tx_byte     <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Done   <= 1'b0;
          baud_cnt    <= '0;
          bit_idx     <= '0;
          if (i_Tx_DV) begin
            // Byte is captured here; later changes on i_Tx_Byte are ignored.
            tx_byte     <= i_Tx_Byte;
            o_Tx_Active <= 1'b1;
            o_Tx_Serial <= 1'b0;
            state       <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_cnt    <= '0;
            bit_idx     <= '0;
            o_Tx_Serial <= tx_byte[0];
            state       <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              // Index stops at 7 and is re-zeroed for reuse as stop-bit counter.
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                o_Tx_Serial <= (^tx_byte) ^ PARITY_ODD[0];
                state       <= S_PARITY;
              end else begin
                o_Tx_Serial <= 1'b1;
                state       <= S_STOP;
              end
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              o_Tx_Serial <= tx_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            baud_cnt    <= '0;
            bit_idx     <= '0;
            o_Tx_Serial <= 1'b1;
            state       <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'(STOP_BITS - 1)) begin
              bit_idx     <= '0;
              o_Tx_Active <= 1'b0;
              o_Tx_Done   <= 1'b1;
              state       <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state       <= S_IDLE;
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          o_Tx_Done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four transmitters (8N1, 8E1, 8O1, 8N2) at 4 clocks per bit.
// Stimulus pushes expected bytes into per-instance queues; a monitor per
// instance pops an entry whenever its transmitter goes active and compares the
// line cycle by cycle against a slot-based frame model.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int N   = 4;

  typedef struct {
    logic [7:0] b;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv      [N];
  logic [7:0] byte_in [N];
  logic       ser     [N];
  logic       act     [N];
  logic       dn      [N];

  exp_t exp_q [N][$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cfg_pen(int k);   return (k == 1 || k == 2) ? 1 : 0; endfunction
  function automatic int cfg_podd(int k);  return (k == 2) ? 1 : 0;           endfunction
  function automatic int cfg_nstop(int k); return (k == 3) ? 2 : 1;           endfunction

  function automatic int frame_len(int k);
    return (10 + cfg_pen(k) + cfg_nstop(k) - 1) * CPB;
  endfunction

  // Line level for a given bit slot of a frame: start, data LSB first,
  // optional parity making the total count of ones even (or odd), then stop.
  function automatic logic exp_bit(int k, logic [7:0] b, int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && cfg_pen(k) != 0) return 1'(($countones(b) + cfg_podd(k)) % 2);
    return 1'b1;
  endfunction

  task automatic check(string name, int actual, int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_inst
    uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (cfg_pen(g)),
      .PARITY_ODD  (cfg_podd(g)),
      .STOP_BITS   (cfg_nstop(g))
    ) u_dut (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .i_Tx_DV    (dv[g]),
      .i_Tx_Byte  (byte_in[g]),
      .o_Tx_Active(act[g]),
      .o_Tx_Serial(ser[g]),
      .o_Tx_Done  (dn[g])
    );

    initial begin : mon
      bit   in_frame;
      int   t;
      int   last_e0;
      exp_t e;
      in_frame = 1'b0;
      t        = 0;
      last_e0  = 0;
      e.b      = '0;
      e.gap    = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          in_frame = 1'b0;
          check($sformatf("rst_serial[%0d]", g), int'(ser[g]), 1);
          check($sformatf("rst_active[%0d]", g), int'(act[g]), 0);
          check($sformatf("rst_done[%0d]", g), int'(dn[g]), 0);
          continue;
        end
        if (!in_frame) begin
          if (act[g] === 1'b1) begin
            check($sformatf("frame_expected[%0d]", g), int'(exp_q[g].size() > 0), 1);
            if (exp_q[g].size() > 0) e = exp_q[g].pop_front();
            else e.gap = 0;
            if (e.gap > 0) check($sformatf("frame_gap[%0d]", g), cyc - last_e0, e.gap);
            last_e0  = cyc;
            in_frame = 1'b1;
            t        = 0;
          end else begin
            check($sformatf("idle_serial[%0d]", g), int'(ser[g]), 1);
            check($sformatf("idle_done[%0d]", g), int'(dn[g]), 0);
          end
        end
        if (in_frame) begin
          if (t < frame_len(g)) begin
            check($sformatf("serial[%0d] byte=%02h slot=%0d", g, e.b, t / CPB),
                  int'(ser[g]), int'(exp_bit(g, e.b, t / CPB)));
            check($sformatf("active[%0d] t=%0d", g, t), int'(act[g]), 1);
            check($sformatf("done_early[%0d] t=%0d", g, t), int'(dn[g]), 0);
          end else begin
            check($sformatf("end_active[%0d]", g), int'(act[g]), 0);
            check($sformatf("end_done[%0d]", g), int'(dn[g]), 1);
            check($sformatf("end_serial[%0d]", g), int'(ser[g]), 1);
            in_frame = 1'b0;
          end
          t++;
        end
      end
    end
  end

  task automatic push_exp(int k, logic [7:0] b, int gap);
    exp_t e;
    e.b   = b;
    e.gap = gap;
    exp_q[k].push_back(e);
  endtask

  task automatic wait_idle(int k);
    int n     = 0;
    int quiet = 0;
    while (quiet < 2 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (exp_q[k].size() == 0 && act[k] === 1'b0) quiet++;
      else quiet = 0;
    end
    check($sformatf("wait_idle[%0d]", k), int'(quiet >= 2), 1);
  endtask

  task automatic wait_act(int k, logic lvl);
    int n = 0;
    while (act[k] !== lvl && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("wait_active[%0d]=%0b", k, lvl), int'(act[k] === lvl), 1);
  endtask

  // One-cycle DV strobe; byte input is scrambled afterwards to prove capture.
  task automatic send(int k, logic [7:0] b);
    push_exp(k, b, 0);
    @(posedge clk);
    #1;
    dv[k]      = 1'b1;
    byte_in[k] = b;
    @(posedge clk);
    #1;
    dv[k]      = 1'b0;
    byte_in[k] = 8'($urandom);
    wait_idle(k);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      dv[k]      = 1'b0;
      byte_in[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Idle after reset: monitors check the line every cycle.
    repeat (50) @(posedge clk);

    // 8N1 single byte.
    send(0, 8'hA5);

    // Continuous DV with byte advancing on each accept, random churn mid-frame.
    push_exp(0, 8'h00, 0);
    push_exp(0, 8'h01, frame_len(0) + 1);
    push_exp(0, 8'h02, frame_len(0) + 1);
    @(posedge clk);
    #1;
    byte_in[0] = 8'h00;
    dv[0]      = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_act(0, 1'b1);
      if (j < 2) begin
        byte_in[0] = 8'($urandom);
        repeat (20) @(posedge clk);
        #1;
        byte_in[0] = 8'(j + 1);
        wait_act(0, 1'b0);
      end else begin
        dv[0] = 1'b0;
      end
    end
    wait_idle(0);

    // Parity corner cases, then 2 stop bits.
    send(1, 8'h07);
    send(2, 8'h07);
    send(1, 8'h00);
    send(3, 8'hFF);

    // Random bytes on every configuration.
    for (int k = 0; k < N; k++) begin
      repeat (4) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        send(k, 8'($urandom));
      end
    end

    // Asynchronous reset mid-data: line must recover before the next edge.
    push_exp(0, 8'($urandom), 0);
    @(posedge clk);
    #1;
    dv[0]      = 1'b1;
    byte_in[0] = exp_q[0][0].b;
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_serial", int'(ser[0]), 1);
    check("async_rst_active", int'(act[0]), 0);
    check("async_rst_done", int'(dn[0]), 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    send(0, 8'h3C);

    for (int k = 0; k < N; k++) check($sformatf("queue_drained[%0d]", k), exp_q[k].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
